multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the datapath mux selects, the write enables and the 2-bit `alu_op` consumed by `aludecode`. It also holds fetch and memory-access states until the memory returns `mem_ready`, and counts retired instructions.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `op`  in  6  opcode field of the instruction register (`instr[31:26]`)
- `mem_ready`  in  1  memory completed the current request this cycle
- `mem_req`  out  1  memory access requested
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  memory write enable
- `ir_write`  out  1  instruction register load
- `pc_write`  out  1  unconditional PC load
- `branch`  out  1  conditional PC load (gated with zero by the datapath)
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_src_a`  out  1  ALU A: 0 = PC, 1 = register A
- `alu_src_b`  out  2  ALU B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct-decoded
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  writeback data: 0 = ALUOut, 1 = memory data
- `reg_write`  out  1  register file write enable
- `illegal_op`  out  1  unsupported opcode seen in DECODE
- `retire`  out  1  one-cycle pulse in the final cycle of each instruction
- `retired_cnt`  out  CNT_W  count of retired instructions
- `state`  out  4  current state, for debug

## Operation
State encoding (4 bits):
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
- RTYPEEX = 6, RTYPEWB = 7, BEQEX = 8, ADDIEX = 9, ADDIWB = 10, JEX = 11

Outputs are Moore outputs, except that the `mem_ready` gating and `illegal_op` are combinational. Every output not listed for a state is 0.
- FETCH: `mem_req` = 1, `alu_src_b` = 01. `ir_write` = `pc_write` = `mem_ready`. Stays in FETCH while `mem_ready` = 0; goes to DECODE when `mem_ready` = 1.
- DECODE: `alu_src_b` = 11. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → RTYPEEX
  - 000100 (beq) → BEQEX
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JEX
  - any other opcode → FETCH with `illegal_op` = 1 (not retired, not counted)
- MEMADR: `alu_src_a` = 1, `alu_src_b` = 10. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_req` = 1, `iord` = 1. Waits for `mem_ready`, then → MEMWB.
- MEMWB: `mem_to_reg` = 1, `reg_write` = 1, `retire` = 1. → FETCH.
- MEMWR: `mem_req` = 1, `iord` = 1, `mem_write` = 1 held for the whole stall. On `mem_ready` = 1: `retire` = 1, → FETCH.
- RTYPEEX: `alu_src_a` = 1, `alu_op` = 10. → RTYPEWB.
- RTYPEWB: `reg_dst` = 1, `reg_write` = 1, `retire` = 1. → FETCH.
- BEQEX: `alu_src_a` = 1, `alu_op` = 01, `branch` = 1, `pc_src` = 01, `retire` = 1. → FETCH.
- ADDIEX: `alu_src_a` = 1, `alu_src_b` = 10. → ADDIWB.
- ADDIWB: `reg_write` = 1, `retire` = 1. → FETCH.
- JEX: `pc_src` = 10, `pc_write` = 1, `retire` = 1. → FETCH.

Counter and illegal states:
- `retired_cnt` increments on every clock edge where `retire` = 1. It wraps modulo 2^CNT_W with no saturation.
- Unused state codes 12–15 go to FETCH on the next edge, with all outputs 0.

## Timing
- `rst` is asynchronous and active-high. While `rst` = 1: `state` = FETCH, `retired_cnt` = 0, and every output is forced to 0, including `mem_req`. Normal FETCH behaviour starts on the first rising edge after `rst` deasserts.
- Reset asserted mid-instruction (including during a stall) aborts the instruction immediately. No retire pulse is issued and no count is recorded.
- Latency with zero stall, counted from FETCH entry:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and addi: 4 cycles
  - beq and j: 3 cycles
  - each cycle with `mem_ready` low in FETCH, MEMRD or MEMWR adds one cycle
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; in all other states it is ignored.
- `op` is sampled only in DECODE and MEMADR. The datapath holds the instruction register stable from the FETCH `ir_write` until the next FETCH.

## Configuration
- `MC_JUMP_EN` defined: JEX is implemented, opcode 000010 is decoded, and `pc_src` = 10 is reachable.
- `MC_JUMP_EN` undefined: JEX is absent and its code 11 is treated as unused. Opcode 000010 takes the illegal path (DECODE → FETCH, `illegal_op` = 1). `pc_src` never exceeds 01.

## Test plan
- Reset, then lw with `mem_ready` = 1 throughout → state sequence 0, 1, 2, 3, 4, 0. `reg_write` and `mem_to_reg` are 1 only in state 4; `retired_cnt` = 1.
- sw with `mem_ready` low for 3 cycles in MEMWR → `mem_write` = 1 for 4 consecutive cycles. `retire` is asserted only in the last of them; total latency is 7 cycles.
- R-type, then beq → `alu_op` = 10 in RTYPEEX and 01 in BEQEX. `branch` = 1 for exactly one cycle; `retired_cnt` advances by 2.
- op = 111111 → DECODE returns to FETCH with `illegal_op` = 1 for one cycle. `retired_cnt` is unchanged and `reg_write`/`mem_write` are never asserted.
- Assert `rst` in MEMRD during a stall → `state` = 0 and all outputs are 0 immediately, before the next clock edge. After release, FETCH resumes and `retired_cnt` = 0.
- j with `MC_JUMP_EN` defined → JEX drives `pc_src` = 10 and `pc_write` = 1. With the macro undefined → `illegal_op` = 1. Separately, with CNT_W = 4, 16 addi instructions → `retired_cnt` wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback one instruction at a time,
// stalls fetch and memory states on mem_ready and counts retired instructions.
// Optional feature: define MC_JUMP_EN to implement the j instruction (JEX).
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_op,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // Moore control word; 'fetch' enables the mem_ready-gated IR/PC loads.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       fetch;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       retire;
  } ctl_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state_q;
  state_t           state_nxt;
  logic             run_q;
  ctl_t             ctl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_legal;

  // Control word driven while in a given state; unlisted fields stay 0.
  function automatic ctl_t moore_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_req = 1'b1; c.fetch = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.retire = 1'b1; end
      S_MEMWR:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = 1'b1; end
      S_RTYPEEX: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_RTYPEWB: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.retire = 1'b1; end
      S_BEQEX:   begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.branch = 1'b1;
        c.pc_src = 2'b01; c.retire = 1'b1;
      end
      S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:  begin c.reg_write = 1'b1; c.retire = 1'b1; end
`ifdef MC_JUMP_EN
      S_JEX:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.retire = 1'b1; end
`endif
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Opcodes this controller knows how to sequence.
  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: op_legal = 1'b1;
`ifdef MC_JUMP_EN
      OP_J:                                    op_legal = 1'b1;
`endif
      default:                                 op_legal = 1'b0;
    endcase
  end

  // Next-state selection; held in FETCH until the first edge after reset.
  always_comb begin
    state_nxt = S_FETCH;
    if (run_q) begin
      case (state_q)
        S_FETCH:   state_nxt = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_nxt = S_MEMADR;
            OP_RTYPE:     state_nxt = S_RTYPEEX;
            OP_BEQ:       state_nxt = S_BEQEX;
            OP_ADDI:      state_nxt = S_ADDIEX;
`ifdef MC_JUMP_EN
            OP_J:         state_nxt = S_JEX;
`endif
            default:      state_nxt = S_FETCH;
          endcase
        end
        S_MEMADR:  state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWR:   state_nxt = mem_ready ? S_FETCH : S_MEMWR;
        S_RTYPEEX: state_nxt = S_RTYPEWB;
        S_ADDIEX:  state_nxt = S_ADDIWB;
        default:   state_nxt = S_FETCH;
      endcase
    end
  end

  // State, registered Moore control word and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      ctl_q   <= '0;
      cnt_q   <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_nxt;
      ctl_q   <= moore_ctl(state_nxt);
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Fetch loads and the MEMWR retire wait on mem_ready in the same cycle.
  assign mem_req     = ctl_q.mem_req;
  assign iord        = ctl_q.iord;
  assign mem_write   = ctl_q.mem_write;
  assign ir_write    = ctl_q.fetch & mem_ready;
  assign pc_write    = ctl_q.pc_write | (ctl_q.fetch & mem_ready);
  assign branch      = ctl_q.branch;
  assign pc_src      = ctl_q.pc_src;
  assign alu_src_a   = ctl_q.alu_src_a;
  assign alu_src_b   = ctl_q.alu_src_b;
  assign alu_op      = ctl_q.alu_op;
  assign reg_dst     = ctl_q.reg_dst;
  assign mem_to_reg  = ctl_q.mem_to_reg;
  assign reg_write   = ctl_q.reg_write;
  assign retire      = ctl_q.retire | (ctl_q.mem_write & mem_ready);
  assign illegal_op  = (state_q == S_DECODE) & ~op_legal;
  assign retired_cnt = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (built with CNT_W = 4 so the
// counter wrap is reachable quickly).
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req, iord, mem_write, ir_write, pc_write, branch;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op, retire;
  logic [3:0] retired_cnt;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_cnt = 4'd0;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RT = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  // {mem_req,iord,mem_write,ir_write,pc_write}, branch, pc_src, alu_src_a,
  // alu_src_b, alu_op, {reg_dst,mem_to_reg,reg_write,retire,illegal_op}
  localparam logic [17:0] E_ZERO = 18'd0;
  localparam logic [17:0] E_FR   = {5'b10011, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 5'b00000};
  localparam logic [17:0] E_FS   = {5'b10000, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 5'b00000};
  localparam logic [17:0] E_DEC  = {5'b00000, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00, 5'b00000};
  localparam logic [17:0] E_DILL = {5'b00000, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00, 5'b00001};
  localparam logic [17:0] E_MADR = {5'b00000, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 5'b00000};
  localparam logic [17:0] E_MRD  = {5'b11000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00000};
  localparam logic [17:0] E_MWB  = {5'b00000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 5'b01110};
  localparam logic [17:0] E_MWS  = {5'b11100, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00000};
  localparam logic [17:0] E_MWR  = {5'b11100, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00010};
  localparam logic [17:0] E_REX  = {5'b00000, 1'b0, 2'b00, 1'b1, 2'b00, 2'b10, 5'b00000};
  localparam logic [17:0] E_RWB  = {5'b00000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 5'b10110};
  localparam logic [17:0] E_BEQ  = {5'b00000, 1'b1, 2'b01, 1'b1, 2'b00, 2'b01, 5'b00010};
  localparam logic [17:0] E_AEX  = {5'b00000, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 5'b00000};
  localparam logic [17:0] E_AWB  = {5'b00000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00110};
  localparam logic [17:0] E_JEX  = {5'b00001, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 5'b00010};

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op),
    .retire(retire), .retired_cnt(retired_cnt), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] outs();
    return {mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src, alu_src_a,
            alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, retire, illegal_op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = OP_RT; mem_ready = 1'b1;
    #1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (outs() !== E_ZERO) begin n_fail++; $display("FAIL reset_outs: got %b expected %b", outs(), E_ZERO); end
    n_checks++; if (retired_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", retired_cnt); end
    tick(); tick();
    n_checks++; if (outs() !== E_ZERO) begin n_fail++; $display("FAIL reset_held_outs: got %b expected %b", outs(), E_ZERO); end
    rst = 1'b0;
    #1;
    n_checks++; if (outs() !== E_ZERO) begin n_fail++; $display("FAIL reset_release_outs: got %b expected %b", outs(), E_ZERO); end
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_first_edge_state: got %0d expected 0", state); end
    n_checks++; if (outs() !== E_FS) begin n_fail++; $display("FAIL reset_fetch_outs: got %b expected %b", outs(), E_FS); end
    exp_cnt = 4'd0;
  endtask

  task automatic test_lw();
    logic [3:0]  st [5];
    logic [17:0] ex [5];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    ex = '{E_FR, E_DEC, E_MADR, E_MRD, E_MWB};
    for (int i = 0; i < 5; i++) begin
      op = OP_LW; mem_ready = 1'b1;
      #1;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      n_checks++; if (outs() !== ex[i]) begin n_fail++; $display("FAIL lw_outs[%0d]: got %b expected %b", i, outs(), ex[i]); end
      tick();
    end
    exp_cnt = exp_cnt + 4'd1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL lw_end_state: got %0d expected 0", state); end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL lw_cnt: got %0d expected %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_sw_stall();
    logic [3:0]  st [7];
    logic [17:0] ex [7];
    logic        mr [7];
    st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    ex = '{E_FR, E_DEC, E_MADR, E_MWS, E_MWS, E_MWS, E_MWR};
    mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      op = OP_SW; mem_ready = mr[i];
      #1;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      n_checks++; if (outs() !== ex[i]) begin n_fail++; $display("FAIL sw_outs[%0d]: got %b expected %b", i, outs(), ex[i]); end
      tick();
    end
    exp_cnt = exp_cnt + 4'd1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL sw_end_state: got %0d expected 0", state); end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL sw_cnt: got %0d expected %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_rtype_beq();
    logic [3:0]  st [7];
    logic [17:0] ex [7];
    logic [5:0]  opv [7];
    st  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8};
    ex  = '{E_FR, E_DEC, E_REX, E_RWB, E_FR, E_DEC, E_BEQ};
    opv = '{OP_RT, OP_RT, OP_RT, OP_RT, OP_BEQ, OP_BEQ, OP_BEQ};
    for (int i = 0; i < 7; i++) begin
      op = opv[i]; mem_ready = 1'b1;
      #1;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL rt_beq_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      n_checks++; if (outs() !== ex[i]) begin n_fail++; $display("FAIL rt_beq_outs[%0d]: got %b expected %b", i, outs(), ex[i]); end
      tick();
    end
    exp_cnt = exp_cnt + 4'd2;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL rt_beq_end_state: got %0d expected 0", state); end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL rt_beq_cnt: got %0d expected %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [2];
    logic [17:0] ex [2];
    st = '{4'd0, 4'd1};
    ex = '{E_FR, E_DILL};
    for (int i = 0; i < 2; i++) begin
      op = OP_BAD; mem_ready = 1'b1;
      #1;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      n_checks++; if (outs() !== ex[i]) begin n_fail++; $display("FAIL illegal_outs[%0d]: got %b expected %b", i, outs(), ex[i]); end
      tick();
    end
    mem_ready = 1'b0;
    #1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL illegal_end_state: got %0d expected 0", state); end
    n_checks++; if (outs() !== E_FS) begin n_fail++; $display("FAIL illegal_end_outs: got %b expected %b", outs(), E_FS); end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL illegal_cnt: got %0d expected %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_addi_fetch_stall();
    logic [3:0]  st [6];
    logic [17:0] ex [6];
    logic        mr [6];
    st = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd9, 4'd10};
    ex = '{E_FS, E_FS, E_FR, E_DEC, E_AEX, E_AWB};
    mr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      op = OP_ADDI; mem_ready = mr[i];
      #1;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      n_checks++; if (outs() !== ex[i]) begin n_fail++; $display("FAIL addi_outs[%0d]: got %b expected %b", i, outs(), ex[i]); end
      tick();
    end
    exp_cnt = exp_cnt + 4'd1;
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL addi_cnt: got %0d expected %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_jump();
`ifdef MC_JUMP_EN
    logic [3:0]  st [3];
    logic [17:0] ex [3];
    st = '{4'd0, 4'd1, 4'd11};
    ex = '{E_FR, E_DEC, E_JEX};
    for (int i = 0; i < 3; i++) begin
      op = OP_J; mem_ready = 1'b1;
      #1;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL jump_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      n_checks++; if (outs() !== ex[i]) begin n_fail++; $display("FAIL jump_outs[%0d]: got %b expected %b", i, outs(), ex[i]); end
      tick();
    end
    exp_cnt = exp_cnt + 4'd1;
`else
    logic [3:0]  st [2];
    logic [17:0] ex [2];
    st = '{4'd0, 4'd1};
    ex = '{E_FR, E_DILL};
    for (int i = 0; i < 2; i++) begin
      op = OP_J; mem_ready = 1'b1;
      #1;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL jump_state[%0d]: got %0d expected %0d", i, state, st[i]); end
      n_checks++; if (outs() !== ex[i]) begin n_fail++; $display("FAIL jump_outs[%0d]: got %b expected %b", i, outs(), ex[i]); end
      tick();
    end
`endif
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL jump_end_state: got %0d expected 0", state); end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL jump_cnt: got %0d expected %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    op = OP_LW; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    #1;
    n_checks++; if (state !== 4'd3) begin n_fail++; $display("FAIL rstmid_pre_state: got %0d expected 3", state); end
    n_checks++; if (outs() !== E_MRD) begin n_fail++; $display("FAIL rstmid_pre_outs: got %b expected %b", outs(), E_MRD); end
    rst = 1'b1;
    #1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d expected 0", state); end
    n_checks++; if (outs() !== E_ZERO) begin n_fail++; $display("FAIL rstmid_outs: got %b expected %b", outs(), E_ZERO); end
    n_checks++; if (retired_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", retired_cnt); end
    exp_cnt = 4'd0;
    mem_ready = 1'b1;
    tick();
    n_checks++; if (outs() !== E_ZERO) begin n_fail++; $display("FAIL rstmid_held_outs: got %b expected %b", outs(), E_ZERO); end
    rst = 1'b0;
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL rstmid_resume_state: got %0d expected 0", state); end
    n_checks++; if (outs() !== E_FS) begin n_fail++; $display("FAIL rstmid_resume_outs: got %b expected %b", outs(), E_FS); end
    n_checks++; if (retired_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_resume_cnt: got %0d expected 0", retired_cnt); end
  endtask

  task automatic test_wrap();
    op = OP_ADDI; mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 4; c++) tick();
      exp_cnt = exp_cnt + 4'd1;
      if (k == 14) begin
        n_checks++; if (retired_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_cnt15: got %0d expected 15", retired_cnt); end
      end
    end
    n_checks++; if (retired_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt0: got %0d expected 0", retired_cnt); end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_cnt_model: got %0d expected %0d", retired_cnt, exp_cnt); end
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL wrap_end_state: got %0d expected 0", state); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype_beq();
    test_illegal();
    test_addi_fetch_stall();
    test_jump();
    test_reset_mid_stall();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
